// File: rtl/fp_op_sequencer.sv
// fp_op_sequencer: front end of the single-precision ALU; resolves IEEE special cases locally, sends the rest to the shared core.
// Latency: accept -> CHECK -> DONE (special) or accept -> CHECK -> BUSY (core cycles, watchdog CORE_TIMEOUT) -> DONE.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; in_ready never depends combinationally on out_ready.
// Build option FPSEQ_SPECIAL_BYPASS_EN: resolve special operands locally; undefined, every operation goes to the core.
module fp_op_sequencer #(
   parameter int CORE_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        core_start,
   output logic [1:0]  core_op,
   output logic [31:0] core_a,
   output logic [31:0] core_b,
   input  logic        core_done,
   input  logic [31:0] core_result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        res_zero,
   output logic        res_inf,
   output logic        res_nan,
   output logic        err_timeout
);

   localparam logic [1:0]  OP_ADD = 2'b00;
   localparam logic [1:0]  OP_SUB = 2'b01;
   localparam logic [1:0]  OP_MUL = 2'b10;
   localparam logic [31:0] QNAN   = 32'h7FC0_0000;
   // Counter only needs 0..CORE_TIMEOUT-1: the last BUSY cycle aborts instead of incrementing.
   localparam int               CNT_W    = $clog2(CORE_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CORE_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, CHECK, BUSY, DONE} state_t;

   typedef struct packed {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } fpReq_t;

   function automatic logic fpIsZero(input logic [30:0] m);
      return m == 31'd0;
   endfunction

   function automatic logic fpIsInf(input logic [30:0] m);
      return (m[30:23] == 8'hFF) && (m[22:0] == 23'd0);
   endfunction

   function automatic logic fpIsNan(input logic [30:0] m);
      return (m[30:23] == 8'hFF) && (m[22:0] != 23'd0);
   endfunction

   state_t           state;
   state_t           nextState;
   fpReq_t           req;
   logic [31:0]      resultReg;
   logic             errReg;
   logic [CNT_W-1:0] busyCnt;
   logic             special;
   logic [31:0]      specialVal;
   logic             acceptReq;
   logic             loadSpecial;
   logic             loadCore;
   logic             loadAbort;
   logic             clrCnt;
   logic             incCnt;
   logic             startPulse;

`ifdef FPSEQ_SPECIAL_BYPASS_EN
   logic aZero, aInf, aNan, bZero, bInf, bNan;
   logic sA, sB, sProd;

   assign aZero = fpIsZero(req.a[30:0]);
   assign aInf  = fpIsInf(req.a[30:0]);
   assign aNan  = fpIsNan(req.a[30:0]);
   assign bZero = fpIsZero(req.b[30:0]);
   assign bInf  = fpIsInf(req.b[30:0]);
   assign bNan  = fpIsNan(req.b[30:0]);
   assign sA    = req.a[31];
   // Subtraction is addition with the sign of b flipped.
   assign sB    = req.b[31] ^ (req.op == OP_SUB);
   assign sProd = req.a[31] ^ req.b[31];

   // Resolve IEEE special operand combinations from the registered request.
   always_comb begin
      special    = 1'b0;
      specialVal = 32'd0;
      if (aNan || bNan) begin
         special    = 1'b1;
         specialVal = QNAN;
      end else begin
         case (req.op)
            OP_ADD, OP_SUB: begin
               if (aInf && bInf && (sA != sB)) begin
                  special    = 1'b1;
                  specialVal = QNAN;
               end else if (aInf) begin
                  special    = 1'b1;
                  specialVal = {sA, 8'hFF, 23'd0};
               end else if (bInf) begin
                  special    = 1'b1;
                  specialVal = {sB, 8'hFF, 23'd0};
               end
            end
            OP_MUL: begin
               if ((aZero && bInf) || (aInf && bZero)) begin
                  special    = 1'b1;
                  specialVal = QNAN;
               end else if (aInf || bInf) begin
                  special    = 1'b1;
                  specialVal = {sProd, 8'hFF, 23'd0};
               end else if (aZero || bZero) begin
                  special    = 1'b1;
                  specialVal = {sProd, 31'd0};
               end
            end
            default: begin
               if ((aZero && bZero) || (aInf && bInf)) begin
                  special    = 1'b1;
                  specialVal = QNAN;
               end else if (aInf || bZero) begin
                  special    = 1'b1;
                  specialVal = {sProd, 8'hFF, 23'd0};
               end else if (aZero || bInf) begin
                  special    = 1'b1;
                  specialVal = {sProd, 31'd0};
               end
            end
         endcase
      end
   end
`else
   // Every operation is dispatched to the core.
   assign special    = 1'b0;
   assign specialVal = 32'd0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state decode and per-cycle control strobes.
   always_comb begin
      nextState   = state;
      acceptReq   = 1'b0;
      loadSpecial = 1'b0;
      loadCore    = 1'b0;
      loadAbort   = 1'b0;
      clrCnt      = 1'b0;
      incCnt      = 1'b0;
      startPulse  = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               acceptReq = 1'b1;
               nextState = CHECK;
            end
         end
         CHECK: begin
            if (special) begin
               loadSpecial = 1'b1;
               nextState   = DONE;
            end else begin
               startPulse = 1'b1;
               clrCnt     = 1'b1;
               nextState  = BUSY;
            end
         end
         BUSY: begin
            // A core_done in the final watchdog cycle still wins over the abort.
            if (core_done) begin
               loadCore  = 1'b1;
               nextState = DONE;
            end else if (busyCnt == CNT_LAST) begin
               loadAbort = 1'b1;
               nextState = DONE;
            end else begin
               incCnt = 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Request capture, watchdog counter, result and timeout flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         req       <= '0;
         resultReg <= 32'd0;
         errReg    <= 1'b0;
         busyCnt   <= '0;
      end else begin
         if (acceptReq) begin
            req    <= {op, a, b};
            errReg <= 1'b0;
         end
         if (clrCnt) begin
            busyCnt <= '0;
         end else if (incCnt) begin
            busyCnt <= busyCnt + CNT_W'(1);
         end
         if (loadSpecial) begin
            resultReg <= specialVal;
         end else if (loadCore) begin
            resultReg <= core_result;
         end else if (loadAbort) begin
            resultReg <= QNAN;
            errReg    <= 1'b1;
         end
      end
   end

   assign in_ready    = (state == IDLE);
   assign out_valid   = (state == DONE);
   assign core_start  = startPulse;
   assign core_op     = req.op;
   assign core_a      = req.a;
   assign core_b      = req.b;
   assign result      = resultReg;
   assign err_timeout = errReg;
   assign res_zero    = fpIsZero(resultReg[30:0]);
   assign res_inf     = fpIsInf(resultReg[30:0]);
   assign res_nan     = fpIsNan(resultReg[30:0]);

endmodule

// File: tb/tb_fp_op_sequencer.sv
`timescale 1ns/1ps
module tb_fp_op_sequencer;

   localparam int          TO   = 64;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;
`ifdef FPSEQ_SPECIAL_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        core_start;
   logic [1:0]  core_op;
   logic [31:0] core_a;
   logic [31:0] core_b;
   logic        core_done = 1'b0;
   logic [31:0] core_result = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        res_zero, res_inf, res_nan, err_timeout;

   fp_op_sequencer #(.CORE_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b),
      .core_start(core_start), .core_op(core_op), .core_a(core_a), .core_b(core_b),
      .core_done(core_done), .core_result(core_result),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .res_zero(res_zero), .res_inf(res_inf), .res_nan(res_nan),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int          nChecks = 0;
   int          nFails  = 0;
   int          startCnt = 0;
   logic [31:0] expRes = 32'd0;
   logic        expErr = 1'b0;
   logic [1:0]  expOp = 2'b00;
   logic [31:0] expA = 32'd0;
   logic [31:0] expB = 32'd0;
   bit          coreBusy = 1'b0;
   logic [31:0] lastRes;
   logic [2:0]  lastFlags;
   logic        lastErr;
   int          lastStarts;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Operand category: 0 finite nonzero, 1 zero, 2 inf, 3 nan.
   function automatic int category(input logic [31:0] x);
      int e, f;
      e = int'((x >> 23) & 32'hFF);
      f = int'(x & 32'h7F_FFFF);
      if (e == 255) return (f == 0) ? 2 : 3;
      if (e == 0 && f == 0) return 1;
      return 0;
   endfunction

   // {zero, inf, nan} of a result value.
   function automatic logic [2:0] flagModel(input logic [31:0] r);
      int c;
      c = category(r);
      return {c == 1, c == 2, c == 3};
   endfunction

   // Returns 1 when the operation is resolved without the core, with its result in r.
   function automatic bit modelSpecial(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                       output logic [31:0] r);
      int  cx, cy;
      bit  sx, sy, sp, hit;
      cx  = category(x);
      cy  = category(y);
      sx  = x[31];
      sy  = y[31] ^ (o == 2'b01);
      sp  = x[31] ^ y[31];
      hit = 1'b1;
      r   = 32'd0;
      if (cx == 3 || cy == 3) r = QNAN;
      else if (o == 2'b00 || o == 2'b01) begin
         if (cx == 2 && cy == 2) r = (sx == sy) ? {sx, 8'hFF, 23'd0} : QNAN;
         else if (cx == 2) r = {sx, 8'hFF, 23'd0};
         else if (cy == 2) r = {sy, 8'hFF, 23'd0};
         else hit = 1'b0;
      end else if (o == 2'b10) begin
         if ((cx == 1 && cy == 2) || (cx == 2 && cy == 1)) r = QNAN;
         else if (cx == 2 || cy == 2) r = {sp, 8'hFF, 23'd0};
         else if (cx == 1 || cy == 1) r = {sp, 31'd0};
         else hit = 1'b0;
      end else begin
         if (cx == cy && (cx == 1 || cx == 2)) r = QNAN;
         else if (cx == 2 || cy == 1) r = {sp, 8'hFF, 23'd0};
         else if (cx == 1 || cy == 2) r = {sp, 31'd0};
         else hit = 1'b0;
      end
      return hit && BYPASS;
   endfunction

   // Every cycle with a meaningful output: result, flags and core bus against the model.
   always @(negedge clk) begin
      if (!rst && out_valid === 1'b1) begin
         check("result", result, expRes);
         check("err_timeout", 32'(err_timeout), 32'(expErr));
         check("res_flags", 32'({res_zero, res_inf, res_nan}), 32'(flagModel(expRes)));
         check("in_ready_in_done", 32'(in_ready), 32'd0);
      end
      if (!rst && coreBusy) begin
         check("core_op", 32'(core_op), 32'(expOp));
         check("core_a", core_a, expA);
         check("core_b", core_b, expB);
      end
      if (core_start === 1'b1) startCnt++;
   end

   // delay: cycles after core_start for core_done (<1 means never); readyDelay: cycles out_ready held low.
   task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int delay, input logic [31:0] coreRes, input int readyDelay);
      logic [31:0] sr;
      bit          sp, seen;
      int          expLat, lat, starts0;
      sp = modelSpecial(o, x, y, sr);
      if (sp) begin
         expRes = sr; expErr = 1'b0; expLat = 1;
      end else if (delay < 1 || delay > TO) begin
         expRes = QNAN; expErr = 1'b1; expLat = TO + 1;
      end else begin
         expRes = coreRes; expErr = 1'b0; expLat = delay + 1;
      end
      expOp = o; expA = x; expB = y;
      starts0 = startCnt;
      @(negedge clk);
      check({tag, " in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, " core_start"}, 32'(core_start), 32'(!sp));
      if (!sp) coreBusy = 1'b1;
      seen = 1'b0;
      lat  = 0;
      for (int c = 1; c <= TO + 10; c++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            seen = 1'b1;
            lat  = c;
            break;
         end
         core_done   = (c == delay);
         core_result = (c == delay) ? coreRes : 32'hDEAD_BEEF;
      end
      core_done = 1'b0;
      coreBusy  = 1'b0;
      if (!seen) begin
         nChecks++;
         nFails++;
         $display("FAIL %s out_valid_wait: never asserted, expected after %0d cycles", tag, expLat);
      end else begin
         check({tag, " latency"}, 32'(lat), 32'(expLat));
      end
      lastRes    = result;
      lastFlags  = {res_zero, res_inf, res_nan};
      lastErr    = err_timeout;
      lastStarts = startCnt - starts0;
      check({tag, " start_count"}, 32'(lastStarts), sp ? 32'd0 : 32'd1);
      for (int i = 0; i < readyDelay; i++) begin
         @(negedge clk);
         check({tag, " hold_valid"}, 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " released"}, 32'(out_valid), 32'd0);
      check({tag, " idle_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int starts0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset core_start", 32'(core_start), 32'd0);
      check("reset err_timeout", 32'(err_timeout), 32'd0);
      check("reset result", result, 32'd0);
      check("reset flags", 32'({res_zero, res_inf, res_nan}), 32'b100);

      // Stray core_done while idle must not produce anything.
      core_done = 1'b1; core_result = 32'h1234_5678;
      @(negedge clk);
      core_done = 1'b0;
      @(negedge clk);
      check("idle core_done ignored", 32'(out_valid), 32'd0);

      runOp("add_core", 2'b00, 32'h3F80_0000, 32'h4000_0000, 5, 32'h4040_0000, 0);
      check("lit add result", lastRes, 32'h4040_0000);
      check("lit add flags", 32'(lastFlags), 32'd0);

      runOp("mul_0_ninf", 2'b10, 32'h0000_0000, 32'hFF80_0000, 3, QNAN, 0);
      check("lit mul result", lastRes, 32'h7FC0_0000);
      check("lit mul flags", 32'(lastFlags), 32'b001);
      check("lit mul starts", 32'(lastStarts), BYPASS ? 32'd0 : 32'd1);

      runOp("div_neg1_0", 2'b11, 32'hBF80_0000, 32'h0000_0000, 2, 32'hFF80_0000, 0);
      check("lit div result", lastRes, 32'hFF80_0000);
      check("lit div flags", 32'(lastFlags), 32'b010);
      check("lit div starts", 32'(lastStarts), BYPASS ? 32'd0 : 32'd1);

      runOp("sub_inf_inf", 2'b01, 32'h7F80_0000, 32'h7F80_0000, 2, 32'h1234_5678, 0);
      runOp("add_nan", 2'b00, 32'h7FC0_0001, 32'h3F80_0000, 1, 32'h0BAD_F00D, 1);
      runOp("mul_negzero", 2'b10, 32'h8000_0000, 32'h3F80_0000, 4, 32'h4000_0000, 0);
      runOp("div_x_inf", 2'b11, 32'h3F80_0000, 32'h7F80_0000, 3, 32'h3F00_0000, 0);
      runOp("div_inf_inf", 2'b11, 32'h7F80_0000, 32'hFF80_0000, 2, 32'h4100_0000, 0);
      runOp("sub_x_ninf", 2'b01, 32'h3F80_0000, 32'hFF80_0000, 2, 32'h4200_0000, 2);
      runOp("mul_done_at_limit", 2'b10, 32'h4000_0000, 32'h4040_0000, TO, 32'h40C0_0000, 0);
      check("lit limit err", 32'(lastErr), 32'd0);

      runOp("add_timeout", 2'b00, 32'h3F80_0000, 32'h3F80_0000, -1, 32'd0, 10);
      check("lit timeout result", lastRes, 32'h7FC0_0000);
      check("lit timeout err", 32'(lastErr), 32'd1);

      runOp("add_after_timeout", 2'b00, 32'h3F00_0000, 32'h3F00_0000, 1, 32'h3F80_0000, 0);
      check("lit err cleared", 32'(lastErr), 32'd0);

      // Reset while the core is busy: aborted op yields no result, late core_done ignored.
      @(negedge clk);
      in_valid = 1'b1; op = 2'b00; a = 32'h3F80_0000; b = 32'h4000_0000;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst out_valid", 32'(out_valid), 32'd0);
      check("midrst core_start", 32'(core_start), 32'd0);
      check("midrst in_ready", 32'(in_ready), 32'd1);
      check("midrst result", result, 32'd0);
      rst = 1'b0;
      starts0 = startCnt;
      @(negedge clk);
      core_done = 1'b1; core_result = 32'h4040_0000;
      @(negedge clk);
      core_done = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("midrst no_result", 32'(out_valid), 32'd0);
      end
      check("midrst no_start", 32'(startCnt - starts0), 32'd0);

      runOp("add_after_rst", 2'b00, 32'h4000_0000, 32'h4000_0000, 2, 32'h4080_0000, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
